// File: rtl/aes256_enc_iter.sv
// Iterative AES-256 encryptor: one round per clock with on-the-fly forward key expansion.
// Define AES256_ENC_LASTKEY_EN to expose the final round key (w56..w59) on last_key.
module aes256_enc_iter #(
  parameter int unsigned NK = 8,
  parameter int unsigned NB = 4,
  parameter int unsigned NR = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [127:0]         plain_text,
  input  logic [4*NK-1:0][7:0] initial_key,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [127:0]         cipher_out
`ifdef AES256_ENC_LASTKEY_EN
  ,
  output logic [127:0]         last_key
`endif
);

  localparam int unsigned BW = 32 * NB;
  localparam logic [3:0] LastRnd = 4'(NR);

  localparam logic [0:255][7:0] SBOX = {
    256'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e         st_q, st_d;
  logic [3:0]     rnd_q, rnd_d;
  logic [BW-1:0]  blk_q, blk_d;
  logic [31:0]    kw_q [8];
  logic [31:0]    kw_d [8];
  logic [127:0]   cipher_q, cipher_d;
  logic           ov_q, ov_d;
`ifdef AES256_ENC_LASTKEY_EN
  logic [127:0]   last_key_q, last_key_d;
`endif

  logic [7:0]     sb [16];
  logic [7:0]     sr [16];
  logic [7:0]     mc [16];
  logic [127:0]   round_key, round_out;
  logic [7:0]     rcon;
  logic [31:0]    temp;
  logic [31:0]    nw [4];
  logic [31:0]    init_w [8];
  logic           accept;

  // Round datapath; state byte 4*c+r is row r of column c, byte 0 at the MSB.
  always_comb begin
    for (int b = 0; b < 16; b++) sb[b] = sbox(blk_q[127-8*b -: 8]);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) sr[4*c+r] = sb[4*((c+r)%4)+r];
    end
    for (int c = 0; c < 4; c++) begin
      mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    round_key = {kw_q[4], kw_q[5], kw_q[6], kw_q[7]};
    for (int b = 0; b < 16; b++) begin
      round_out[127-8*b -: 8] = ((rnd_q == LastRnd) ? sr[b] : mc[b]) ^ round_key[127-8*b -: 8];
    end
  end

  // Next four key words; odd rounds start on an i mod 8 == 0 word, even on i mod 8 == 4.
  always_comb begin
    rcon  = 8'h01 << ((rnd_q - 4'd1) >> 1);
    temp  = rnd_q[0] ? (sub_word({kw_q[7][23:0], kw_q[7][31:24]}) ^ {rcon, 24'h0})
                     : sub_word(kw_q[7]);
    nw[0] = kw_q[0] ^ temp;
    nw[1] = kw_q[1] ^ nw[0];
    nw[2] = kw_q[2] ^ nw[1];
    nw[3] = kw_q[3] ^ nw[2];
    for (int j = 0; j < 8; j++) begin
      init_w[j] = {initial_key[4*j], initial_key[4*j+1], initial_key[4*j+2], initial_key[4*j+3]};
    end
  end

  always_comb begin
    st_d     = st_q;
    rnd_d    = rnd_q;
    blk_d    = blk_q;
    kw_d     = kw_q;
    cipher_d = cipher_q;
    ov_d     = ov_q;
`ifdef AES256_ENC_LASTKEY_EN
    last_key_d = last_key_q;
`endif
    in_ready = rst & ((st_q == StIdle) | ((st_q == StDone) & out_ready));
    accept   = in_valid & in_ready;

    unique case (st_q)
      StBusy: begin
        blk_d = round_out;
        kw_d  = '{kw_q[4], kw_q[5], kw_q[6], kw_q[7], nw[0], nw[1], nw[2], nw[3]};
        if (rnd_q == LastRnd) begin
          cipher_d = round_out;
          ov_d     = 1'b1;
          st_d     = StDone;
`ifdef AES256_ENC_LASTKEY_EN
          last_key_d = round_key;
`endif
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      StDone: begin
        if (out_ready) begin
          ov_d = 1'b0;
          st_d = StIdle;
        end
      end
      default: ;
    endcase

    // Accept is only possible in IDLE or in DONE with out_ready (back-to-back).
    if (accept) begin
      blk_d = plain_text ^ {init_w[0], init_w[1], init_w[2], init_w[3]};
      kw_d  = init_w;
      rnd_d = 4'd1;
      st_d  = StBusy;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q     <= StIdle;
      rnd_q    <= 4'd0;
      blk_q    <= '0;
      kw_q     <= '{default: '0};
      cipher_q <= '0;
      ov_q     <= 1'b0;
`ifdef AES256_ENC_LASTKEY_EN
      last_key_q <= '0;
`endif
    end else begin
      st_q     <= st_d;
      rnd_q    <= rnd_d;
      blk_q    <= blk_d;
      kw_q     <= kw_d;
      cipher_q <= cipher_d;
      ov_q     <= ov_d;
`ifdef AES256_ENC_LASTKEY_EN
      last_key_q <= last_key_d;
`endif
    end
  end

  assign out_valid  = ov_q;
  assign cipher_out = cipher_q;
`ifdef AES256_ENC_LASTKEY_EN
  assign last_key   = last_key_q;
`endif

endmodule

// File: tb/tb_aes256_enc_iter.sv
// Directed-vector bench for aes256_enc_iter (FIPS-197 C.3, zero-key vector, handshake, reset).
module tb_aes256_enc_iter;

  localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] C3_LK  = 128'h24fc79ccbf0979e9371ac23c6d68de36;
  localparam logic [127:0] ZERO_CT = 128'hdc95c078a2408989ad48a21492842087;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [127:0]        plain_text;
  logic [31:0][7:0]    initial_key;
  logic                out_valid;
  logic                out_ready;
  logic [127:0]        cipher_out;
`ifdef AES256_ENC_LASTKEY_EN
  logic [127:0]        last_key;
`endif

  int n_vec = 0;
  int n_err = 0;

  aes256_enc_iter dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plain_text (plain_text),
    .initial_key(initial_key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef AES256_ENC_LASTKEY_EN
    .last_key   (last_key),
`endif
    .cipher_out (cipher_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  function automatic logic [31:0][7:0] c3_key();
    logic [31:0][7:0] k;
    for (int i = 0; i < 32; i++) k[i] = 8'(i);
    return k;
  endfunction

  task automatic start_block(input logic [127:0] pt, input logic [31:0][7:0] key,
                             output bit ok);
    int n;
    @(negedge clk);
    plain_text  = pt;
    initial_key = key;
    in_valid    = 1'b1;
    #1;
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    ok = (in_ready === 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Negedges after the accept edge until out_valid is seen.
  task automatic wait_done(output int k);
    k = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid: got %b required 0", out_valid);
    end
    n_vec++;
    if (cipher_out !== 128'h0) begin
      n_err++; $display("FAIL reset_cipher: got %h required 0", cipher_out);
    end
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_in_ready: got %b required 0", in_ready);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_fips_c3();
    bit ok;
    int k;
    out_ready = 1'b0;
    start_block(C3_PT, c3_key(), ok);
    n_vec++;
    if (!ok) begin
      n_err++; $display("FAIL c3_accept: got in_ready low required accept");
    end
    wait_done(k);
    n_vec++;
    if (k != 14) begin
      n_err++; $display("FAIL c3_latency: got %0d required 14", k);
    end
    n_vec++;
    if (cipher_out !== C3_CT) begin
      n_err++; $display("FAIL c3_cipher: got %h required %h", cipher_out, C3_CT);
    end
`ifdef AES256_ENC_LASTKEY_EN
    n_vec++;
    if (last_key !== C3_LK) begin
      n_err++; $display("FAIL c3_last_key: got %h required %h", last_key, C3_LK);
    end
`endif
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || cipher_out !== C3_CT || in_ready !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++; $display("FAIL hold_stable: got %0d unstable cycles required 0", bad);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL done_ready_passthru: got %b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL release_out_valid: got %b required 0", out_valid);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL release_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int k;
    start_block(C3_PT, c3_key(), ok);
    wait_done(k);
    n_vec++;
    if (k != 14 || cipher_out !== C3_CT) begin
      n_err++; $display("FAIL b2b_first: got %h after %0d required %h", cipher_out, k, C3_CT);
    end
    @(negedge clk);
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    plain_text  = 128'h0;
    initial_key = '0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL b2b_ready: got in_ready %b out_valid %b required 1 1",
                        in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    wait_done(k);
    n_vec++;
    if (k != 14) begin
      n_err++; $display("FAIL b2b_latency: got %0d required 14", k);
    end
    n_vec++;
    if (cipher_out !== ZERO_CT) begin
      n_err++; $display("FAIL b2b_cipher: got %h required %h", cipher_out, ZERO_CT);
    end
    drain();
  endtask

  task automatic test_input_stability();
    bit ok;
    int k;
    int bad;
    out_ready = 1'b0;
    start_block(C3_PT, c3_key(), ok);
    k = 0;
    bad = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && k < 40) begin
      plain_text  = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 32; i++) initial_key[i] = 8'($urandom);
      in_valid = 1'($urandom);
      #1;
      if (in_ready !== 1'b0) bad++;
      @(negedge clk);
      k++;
    end
    in_valid = 1'b0;
    n_vec++;
    if (bad != 0) begin
      n_err++; $display("FAIL busy_in_ready: got %0d ready cycles required 0", bad);
    end
    n_vec++;
    if (k != 14) begin
      n_err++; $display("FAIL stab_latency: got %0d required 14", k);
    end
    n_vec++;
    if (cipher_out !== C3_CT) begin
      n_err++; $display("FAIL stab_cipher: got %h required %h", cipher_out, C3_CT);
    end
    drain();
  endtask

  task automatic test_reset_mid_busy();
    bit ok;
    int k;
    out_ready = 1'b0;
    start_block(C3_PT, c3_key(), ok);
    repeat (7) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL midrst_out_valid: got %b required 0", out_valid);
    end
    n_vec++;
    if (cipher_out !== 128'h0) begin
      n_err++; $display("FAIL midrst_cipher: got %h required 0", cipher_out);
    end
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL midrst_in_ready: got %b required 0", in_ready);
    end
`ifdef AES256_ENC_LASTKEY_EN
    n_vec++;
    if (last_key !== 128'h0) begin
      n_err++; $display("FAIL midrst_last_key: got %h required 0", last_key);
    end
`endif
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL midrst_idle: got in_ready %b required 1", in_ready);
    end
    start_block(C3_PT, c3_key(), ok);
    wait_done(k);
    n_vec++;
    if (k != 14 || cipher_out !== C3_CT) begin
      n_err++; $display("FAIL midrst_rerun: got %h after %0d required %h after 14",
                        cipher_out, k, C3_CT);
    end
    drain();
  endtask

  initial begin
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    plain_text  = '0;
    initial_key = '0;
    rst         = 1'b0;
    test_reset();
    test_fips_c3();
    test_backpressure();
    test_back_to_back();
    test_input_stability();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
